z80_bus_arbiter: RTL and testbench
==================================

Z80_BUS_ARBITER -- requirements
Module: z80_bus_arbiter

Interface
REQ-001 Parameters SHALL be:
- DIV, 15, Z80 clock divide ratio in MCLK cycles, range 4..31.
- HIGH, 7, MCLK cycles per period with z80_clk high, range 1..DIV-1.
- RST_MIN, 3, minimum Z80 reset width in z80_clk rising edges, range 1..15.

REQ-002 Ports SHALL be (name, direction, width, meaning):
- MCLK, in, 1, master clock; all state updates on its rising edge.
- rst, in, 1, synchronous active-high reset.
- busreq_wr, in, 1, one-cycle strobe: host writes the bus-request register.
- busreq_din, in, 1, value written with busreq_wr; 1 = request the Z80 bus.
- zreset_wr, in, 1, one-cycle strobe: host writes the Z80 reset register.
- zreset_din, in, 1, value written with zreset_wr; 0 = hold the Z80 in reset, 1 = release it.
- z80_busak_n, in, 1, Z80 bus acknowledge, active low, asynchronous to MCLK.
- access_req, in, 1, host access to Z80 address space this cycle.
- z80_clk, out, 1, Z80 CLK input.
- z80_busrq_n, out, 1, Z80 BUSRQ, active low.
- z80_reset_n, out, 1, Z80 RESET, active low.
- bus_granted, out, 1, host owns the Z80 bus.
- busreq_status, out, 1, host read-back bit; equals ~bus_granted.
- access_ok, out, 1, registered acceptance of access_req.
- access_err, out, 1, registered one-cycle pulse: access_req seen without a grant.

REQ-003 Reset is rst, synchronous, active-high; the clock is MCLK.

Function
REQ-010 The clock divider SHALL use a counter cnt that runs 0..DIV-1 and wraps to 0, advancing every MCLK.
REQ-011 z80_clk SHALL be a registered output, 1 when cnt < HIGH and 0 otherwise.
REQ-012 zrise SHALL be an internal one-MCLK strobe asserted when cnt wraps from DIV-1 to 0.
REQ-013 req_reg SHALL load busreq_din on busreq_wr; rel_reg SHALL load zreset_din on zreset_wr; both hold their value otherwise.
REQ-014 On a 1->0 write of rel_reg, stretch counter scnt SHALL load RST_MIN.
REQ-015 scnt SHALL decrement on each zrise while nonzero and saturate at 0.
REQ-016 z80_reset_n SHALL be 0 while rel_reg=0 or scnt!=0, and 1 otherwise; it is registered.
REQ-017 z80_busak_n SHALL pass through a two-flop synchronizer; the output is ak_s, active low.
REQ-018 The FSM SHALL have states RUN, REQ, GRANT, REL, encoded as 2 bits.
REQ-019 RUN: z80_busrq_n=1, bus_granted=0; move to REQ when req_reg=1.
REQ-020 REQ: z80_busrq_n=0; move to GRANT when ak_s=0 or z80_reset_n=0; move to RUN when req_reg=0 and no grant condition is true.
REQ-021 In REQ, if the grant condition and req_reg=0 occur in the same cycle, the FSM SHALL move to RUN.
REQ-022 GRANT: z80_busrq_n=0, bus_granted=1; move to REL when req_reg=0.
REQ-023 A Z80 reset assertion during GRANT SHALL NOT change state.
REQ-024 REL: z80_busrq_n=1, bus_granted=0; move to RUN when ak_s=1 or z80_reset_n=0.
REQ-025 In REL, req_reg=1 SHALL be ignored until RUN is reached; RUN then re-enters REQ on the next cycle.
REQ-026 All FSM outputs SHALL be registered and reflect the state entered, one MCLK after the transition condition.
REQ-027 busreq_status SHALL equal ~bus_granted at all times.
REQ-028 access_ok SHALL be the registered value of (access_req & bus_granted).
REQ-029 access_err SHALL be the registered value of (access_req & ~bus_granted); it is high for exactly one MCLK per requesting cycle.
REQ-030 Latency from busreq_wr(1) in RUN to z80_busrq_n=0 SHALL be 2 MCLK: register load, then FSM.
REQ-031 Latency from z80_busak_n falling to bus_granted=1 SHALL be at most 3 MCLK.
REQ-032 busreq_wr and zreset_wr in the same cycle SHALL both take effect.

Reset
REQ-040 rst SHALL set: cnt=0, z80_clk=1, req_reg=0, rel_reg=0, scnt=RST_MIN, state=RUN.
REQ-041 rst SHALL set outputs: z80_busrq_n=1, z80_reset_n=0, bus_granted=0, busreq_status=1, access_ok=0, access_err=0.
REQ-042 The synchronizer flops SHALL reset to 1.
REQ-043 rst SHALL take priority over every write strobe in the same cycle.

Verification
REQ-050 Divider: after rst, z80_clk SHALL be high 7 / low 8 MCLK with period exactly 15, repeating for 100 periods.
REQ-051 Reset stretch:
- Stimulus: zreset_wr din=0, then 1 MCLK later zreset_wr din=1.
- Response: z80_reset_n stays 0 until the 3rd zrise after the assert, then goes 1.
REQ-052 Handshake:
- Stimulus: Z80 out of reset; busreq_wr din=1; model drives busak_n low 10 MCLK after busrq_n falls.
- Response: busrq_n=0 at +2; bus_granted=1 within 3 MCLK of busak_n low; busreq_status=0.
- Stimulus: busreq_wr din=0; model raises busak_n 5 MCLK later.
- Response: busrq_n=1; bus_granted=0; RUN reached within 3 MCLK of busak_n high.
REQ-053 Abort:
- Stimulus: busreq_wr 1, then busreq_wr 0 before busak_n falls.
- Response: FSM returns to RUN; bus_granted never asserts; busrq_n=1.
REQ-054 Reset-grant:
- Stimulus: rel_reg=0 with busak_n held high; busreq_wr 1.
- Response: bus_granted=1 within 3 MCLK.
REQ-055 Access check:
- Stimulus: access_req pulsed in RUN, then again in GRANT.
- Response: first pulse gives access_err=1, access_ok=0; second gives access_ok=1, access_err=0.

Source files
------------

// File: rtl/z80_bus_arbiter.sv
// ----------------------------------------------------------------------------
// z80_bus_arbiter
//
// Lets a host CPU take over the address space of a slave Z80. The block
// generates the Z80 clock, applies a stretched Z80 reset, and runs the
// BUSRQ/BUSAK handshake that grants the bus to the host.
//
// Parameters
//   DIV      Z80 clock divide ratio in MCLK cycles (4..31)
//   HIGH     MCLK cycles per period with z80_clk high (1..DIV-1)
//   RST_MIN  minimum Z80 reset width in z80_clk rising edges (1..15)
//
// Ports
//   MCLK           master clock, every register updates on its rising edge
//   rst            synchronous active-high reset
//   busreq_wr/din  host write of the bus-request bit (1 = request the bus)
//   zreset_wr/din  host write of the Z80 reset bit (0 = hold, 1 = release)
//   z80_busak_n    Z80 BUSAK, active low, asynchronous to MCLK
//   access_req     host access to Z80 address space this cycle
//   z80_clk        Z80 CLK
//   z80_busrq_n    Z80 BUSRQ, active low
//   z80_reset_n    Z80 RESET, active low
//   bus_granted    host currently owns the Z80 bus
//   busreq_status  host read-back bit, always ~bus_granted
//   access_ok      registered access_req & bus_granted
//   access_err     registered access_req & ~bus_granted
// ----------------------------------------------------------------------------
module z80_bus_arbiter #(
    parameter int unsigned DIV     = 15,
    parameter int unsigned HIGH    = 7,
    parameter int unsigned RST_MIN = 3
) (
    input  logic MCLK,
    input  logic rst,
    input  logic busreq_wr,
    input  logic busreq_din,
    input  logic zreset_wr,
    input  logic zreset_din,
    input  logic z80_busak_n,
    input  logic access_req,
    output logic z80_clk,
    output logic z80_busrq_n,
    output logic z80_reset_n,
    output logic bus_granted,
    output logic busreq_status,
    output logic access_ok,
    output logic access_err
);

    // 5 bits cover the whole DIV range, 4 bits the whole RST_MIN range.
    localparam int CW = 5;
    localparam int SW = 4;

    localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
    localparam logic [CW-1:0] CNT_HIGH = CW'(HIGH);
    localparam logic [SW-1:0] SCNT_INIT = SW'(RST_MIN);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_REQ   = 2'd1,
        ST_GRANT = 2'd2,
        ST_REL   = 2'd3
    } state_t;

    // ------------------------------------------------------------------------
    // Clock divider
    // ------------------------------------------------------------------------
    logic [CW-1:0] cnt_q, cnt_d;
    logic          z80_clk_q, z80_clk_d;
    logic          zrise;

    // zrise marks the MCLK edge on which cnt wraps to 0, which is also the
    // edge on which z80_clk goes high.
    assign zrise = (cnt_q == CNT_LAST);

    // NOTE: every variable driven in an always_comb gets a value on all paths
    // (here by construction, elsewhere by a default first); a missing branch
    // would infer a latch.
    always_comb begin
        cnt_d     = zrise ? '0 : cnt_q + CW'(1);
        // Registered from the next count so z80_clk always matches cnt_q.
        z80_clk_d = (cnt_d < CNT_HIGH);
    end

    // ------------------------------------------------------------------------
    // Host registers and Z80 reset stretch
    // ------------------------------------------------------------------------
    logic          req_q, req_d;
    logic          rel_q, rel_d;
    logic [SW-1:0] scnt_q, scnt_d;
    logic          reset_n_q, reset_n_d;

    always_comb begin
        req_d  = busreq_wr ? busreq_din : req_q;
        rel_d  = zreset_wr ? zreset_din : rel_q;
        scnt_d = scnt_q;
        // A fresh assertion restarts the stretch even if it lands on a zrise.
        if (zreset_wr && !zreset_din && rel_q) begin
            scnt_d = SCNT_INIT;
        end else if (zrise && (scnt_q != '0)) begin
            scnt_d = scnt_q - SW'(1);
        end
        // Built from next-state values so RESET releases on the very edge the
        // last stretch count expires.
        reset_n_d = rel_d && (scnt_d == '0);
    end

    // ------------------------------------------------------------------------
    // BUSAK synchronizer
    // ------------------------------------------------------------------------
    logic ak_meta_q;
    logic ak_s_q;

    // ------------------------------------------------------------------------
    // Handshake FSM
    // ------------------------------------------------------------------------
    state_t state_q, state_d;
    logic   busrq_n_q, busrq_n_d;
    logic   granted_q, granted_d;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_RUN: begin
                if (req_q) begin
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                // Withdrawal wins over a grant arriving in the same cycle.
                // A Z80 held in reset cannot drive the bus, so it counts as
                // an acknowledge.
                if (!req_q) begin
                    state_d = ST_RUN;
                end else if (!ak_s_q || !reset_n_q) begin
                    state_d = ST_GRANT;
                end
            end
            ST_GRANT: begin
                if (!req_q) begin
                    state_d = ST_REL;
                end
            end
            ST_REL: begin
                // A new request waits in req_q until RUN picks it up.
                if (ak_s_q || !reset_n_q) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_RUN;
        endcase

        // Outputs are decoded from the state being entered and registered,
        // so they change together with state_q.
        busrq_n_d = !((state_d == ST_REQ) || (state_d == ST_GRANT));
        granted_d = (state_d == ST_GRANT);
    end

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    logic access_ok_q;
    logic access_err_q;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge MCLK) begin
        if (rst) begin
            cnt_q        <= '0;
            z80_clk_q    <= 1'b1;
            req_q        <= 1'b0;
            rel_q        <= 1'b0;
            scnt_q       <= SCNT_INIT;
            reset_n_q    <= 1'b0;
            ak_meta_q    <= 1'b1;
            ak_s_q       <= 1'b1;
            state_q      <= ST_RUN;
            busrq_n_q    <= 1'b1;
            granted_q    <= 1'b0;
            access_ok_q  <= 1'b0;
            access_err_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            z80_clk_q    <= z80_clk_d;
            req_q        <= req_d;
            rel_q        <= rel_d;
            scnt_q       <= scnt_d;
            reset_n_q    <= reset_n_d;
            ak_meta_q    <= z80_busak_n;
            ak_s_q       <= ak_meta_q;
            state_q      <= state_d;
            busrq_n_q    <= busrq_n_d;
            granted_q    <= granted_d;
            access_ok_q  <= access_req & granted_q;
            access_err_q <= access_req & ~granted_q;
        end
    end

    assign z80_clk       = z80_clk_q;
    assign z80_busrq_n   = busrq_n_q;
    assign z80_reset_n   = reset_n_q;
    assign bus_granted   = granted_q;
    assign busreq_status = ~granted_q;
    assign access_ok     = access_ok_q;
    assign access_err    = access_err_q;

endmodule

// File: tb/tb_z80_bus_arbiter.sv
// ----------------------------------------------------------------------------
// tb_z80_bus_arbiter
//
// Directed bench for z80_bus_arbiter with default parameters (DIV=15,
// HIGH=7, RST_MIN=3). Inputs change 1 ns after a rising MCLK edge and outputs
// are read at that same point, so each read shows the result of the edge
// just taken.
// ----------------------------------------------------------------------------
module tb_z80_bus_arbiter;

    logic MCLK = 1'b0;
    logic rst;
    logic busreq_wr, busreq_din;
    logic zreset_wr, zreset_din;
    logic z80_busak_n;
    logic access_req;
    logic z80_clk, z80_busrq_n, z80_reset_n;
    logic bus_granted, busreq_status, access_ok, access_err;

    int n_checks = 0;
    int n_errors = 0;

    always #5 MCLK = ~MCLK;

    z80_bus_arbiter #(
        .DIV    (15),
        .HIGH   (7),
        .RST_MIN(3)
    ) dut (
        .MCLK         (MCLK),
        .rst          (rst),
        .busreq_wr    (busreq_wr),
        .busreq_din   (busreq_din),
        .zreset_wr    (zreset_wr),
        .zreset_din   (zreset_din),
        .z80_busak_n  (z80_busak_n),
        .access_req   (access_req),
        .z80_clk      (z80_clk),
        .z80_busrq_n  (z80_busrq_n),
        .z80_reset_n  (z80_reset_n),
        .bus_granted  (bus_granted),
        .busreq_status(busreq_status),
        .access_ok    (access_ok),
        .access_err   (access_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge MCLK);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [14:0] pat;
        logic        prev_clk;
        logic        seen;
        int          rises;
        int          n;

        rst         = 1'b1;
        busreq_wr   = 1'b0;
        busreq_din  = 1'b0;
        zreset_wr   = 1'b0;
        zreset_din  = 1'b0;
        z80_busak_n = 1'b1;
        access_req  = 1'b0;
        step();
        step();

        // Write strobes during the last reset edge must be ignored.
        busreq_wr  = 1'b1;
        busreq_din = 1'b1;
        zreset_wr  = 1'b1;
        zreset_din = 1'b1;
        step();
        rst        = 1'b0;
        busreq_wr  = 1'b0;
        busreq_din = 1'b0;
        zreset_wr  = 1'b0;
        zreset_din = 1'b0;

        check("rst_z80_clk",  z80_clk,       1);
        check("rst_busrq_n",  z80_busrq_n,   1);
        check("rst_reset_n",  z80_reset_n,   0);
        check("rst_granted",  bus_granted,   0);
        check("rst_status",   busreq_status, 1);
        check("rst_acc_ok",   access_ok,     0);
        check("rst_acc_err",  access_err,    0);

        // Divider: 7 high then 8 low, first sample is the reset edge.
        for (int p = 0; p < 100; p++) begin
            for (int i = 0; i < 15; i++) begin
                pat[i] = z80_clk;
                step();
            end
            check("div_period", 32'(pat), 32'h0000_007F);
        end

        // Strobes that coincided with rst left both registers at 0.
        check("rst_prio_busrq", z80_busrq_n, 1);
        check("rst_prio_reset", z80_reset_n, 0);

        // Release the Z80; the power-on stretch has long expired.
        zreset_wr  = 1'b1;
        zreset_din = 1'b1;
        step();
        zreset_wr  = 1'b0;
        check("release_reset_n", z80_reset_n, 1);

        // Reset stretch: assert then release one MCLK later.
        zreset_wr  = 1'b1;
        zreset_din = 1'b0;
        step();
        check("stretch_assert", z80_reset_n, 0);
        prev_clk   = z80_clk;
        zreset_din = 1'b1;
        rises      = 0;
        seen       = 1'b0;
        n          = 0;
        while (rises < 3 && n < 100) begin
            step();
            zreset_wr = 1'b0;
            n++;
            if (!prev_clk && z80_clk) rises++;
            prev_clk = z80_clk;
            if (rises < 3 && z80_reset_n) seen = 1'b1;
        end
        check("stretch_zrises",  rises,       3);
        check("stretch_early",   seen,        0);
        check("stretch_release", z80_reset_n, 1);

        // Handshake: request with the Z80 running.
        busreq_wr  = 1'b1;
        busreq_din = 1'b1;
        step();
        busreq_wr  = 1'b0;
        check("hs_busrq_lat1", z80_busrq_n, 1);
        step();
        check("hs_busrq_lat2", z80_busrq_n, 0);
        seen = 1'b0;
        repeat (9) begin
            step();
            if (bus_granted) seen = 1'b1;
        end
        check("hs_no_early_grant", seen, 0);
        z80_busak_n = 1'b0;
        n = 0;
        while (!bus_granted && n < 3) begin
            step();
            n++;
        end
        check("hs_granted", bus_granted,   1);
        check("hs_status",  busreq_status, 0);
        check("hs_busrq",   z80_busrq_n,   0);

        // Release: GRANT -> REL two edges after the write.
        busreq_wr  = 1'b1;
        busreq_din = 1'b0;
        step();
        busreq_wr  = 1'b0;
        check("rel_hold_grant", bus_granted, 1);
        step();
        check("rel_granted", bus_granted,   0);
        check("rel_busrq",   z80_busrq_n,   1);
        check("rel_status",  busreq_status, 1);

        // A new request while in REL must wait for BUSAK to go high.
        busreq_wr  = 1'b1;
        busreq_din = 1'b1;
        step();
        busreq_wr  = 1'b0;
        seen = 1'b0;
        repeat (3) begin
            step();
            if (!z80_busrq_n || bus_granted) seen = 1'b1;
        end
        check("rel_ignores_req", seen, 0);
        z80_busak_n = 1'b1;
        repeat (3) step();
        check("rel_run_busrq", z80_busrq_n, 1);
        step();
        check("run_reenter_req", z80_busrq_n, 0);

        // Abort: withdraw the request before BUSAK falls.
        busreq_wr  = 1'b1;
        busreq_din = 1'b0;
        seen = 1'b0;
        step();
        busreq_wr = 1'b0;
        if (bus_granted) seen = 1'b1;
        check("abort_busrq_hold", z80_busrq_n, 0);
        step();
        check("abort_busrq", z80_busrq_n, 1);
        repeat (4) begin
            step();
            if (bus_granted || !z80_busrq_n) seen = 1'b1;
        end
        check("abort_quiet", seen, 0);

        // Reset-grant, with both host registers written in the same cycle.
        busreq_wr  = 1'b1;
        busreq_din = 1'b1;
        zreset_wr  = 1'b1;
        zreset_din = 1'b0;
        step();
        busreq_wr  = 1'b0;
        zreset_wr  = 1'b0;
        check("simul_reset_n", z80_reset_n, 0);
        n = 1;
        while (!bus_granted && n < 3) begin
            step();
            n++;
        end
        check("rstgrant_granted", bus_granted, 1);

        // Re-asserting Z80 reset during GRANT keeps the grant.
        zreset_wr  = 1'b1;
        zreset_din = 1'b1;
        step();
        zreset_din = 1'b0;
        step();
        zreset_wr = 1'b0;
        repeat (3) step();
        check("grant_hold_reset_n", z80_reset_n, 0);
        check("grant_hold",         bus_granted, 1);

        // Drop the request; REL exits at once because the Z80 is in reset.
        busreq_wr  = 1'b1;
        busreq_din = 1'b0;
        step();
        busreq_wr = 1'b0;
        step();
        step();
        check("rstrel_granted", bus_granted, 0);
        check("rstrel_busrq",   z80_busrq_n, 1);

        // Access without a grant.
        access_req = 1'b1;
        step();
        access_req = 1'b0;
        check("acc_run_err", access_err, 1);
        check("acc_run_ok",  access_ok,  0);
        step();
        check("acc_run_err_pulse", access_err, 0);

        // Access with a grant.
        busreq_wr  = 1'b1;
        busreq_din = 1'b1;
        step();
        busreq_wr = 1'b0;
        n = 1;
        while (!bus_granted && n < 4) begin
            step();
            n++;
        end
        check("acc_granted", bus_granted, 1);
        access_req = 1'b1;
        step();
        access_req = 1'b0;
        check("acc_grant_ok",  access_ok,  1);
        check("acc_grant_err", access_err, 0);
        step();
        check("acc_grant_ok_pulse", access_ok, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
